pu_unpack: RTL and testbench



---
 rtl/pu_unpack_pkg.sv | 18 +
 rtl/pu_unpack_extract.sv | 38 +++
 rtl/pu_unpack.sv | 95 +++++++++
 tb/tb_pu_unpack.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_unpack_pkg.sv
// Shared definitions for the field-unpacking processing unit: drain states,
// attribute bit positions and pointer sizing.
package pu_unpack_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADED  = 2'd1,
    ST_DRAINED = 2'd2
  } unpack_state_e;

  localparam int ATTR_INVALID_BIT = 0;

  // Pointer must be able to hold DATA_WIDTH itself (fully drained word).
  function automatic int ptr_bits(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/pu_unpack_extract.sv
// Combinational field extractor: returns w bits of word starting at ptr,
// zero-extended, and flags reads that run past the end of the word.
module pu_unpack_extract
  import pu_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int PTR_W      = ptr_bits(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [PTR_W-1:0]      ptr,
  input  logic [SEL_WIDTH:0]    w,
  output logic [DATA_WIDTH-1:0] field,
  output logic                  overrun
);

  localparam int SUM_W = ((PTR_W > SEL_WIDTH + 1) ? PTR_W : SEL_WIDTH + 1) + 1;
  localparam logic [SUM_W-1:0] SUM_END = SUM_W'(DATA_WIDTH);

  logic [SUM_W-1:0]      w_ext;
  logic [SUM_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] mask;

  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    w_ext   = SUM_W'(w);
    sum     = SUM_W'(ptr) + w_ext;
    overrun = (sum > SUM_END);
    shifted = word >> ptr;
    mask    = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = (SUM_W'(i) < w_ext);
    end
    field = shifted & mask;
  end

endmodule

// File: rtl/pu_unpack.sv
// PU bus unit that splits a loaded word into consecutive variable-width
// fields, LSB first; reads are combinational and advance the pointer on clk.
module pu_unpack
  import pu_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic                  signal_oe,
  input  logic [SEL_WIDTH-1:0]  signal_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out
);

  localparam int PTR_W = ptr_bits(DATA_WIDTH);
  localparam int SUM_W = ((PTR_W > SEL_WIDTH + 1) ? PTR_W : SEL_WIDTH + 1) + 1;
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(DATA_WIDTH);
  localparam logic [SUM_W-1:0] SUM_END = SUM_W'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] word_q;
  logic [ATTR_WIDTH-1:0] attr_q;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  unpack_state_e         st_q, st_d;

  logic [SEL_WIDTH:0]    w;
  logic [SUM_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] field;
  logic                  overrun;
  logic                  invalid;
  logic [ATTR_WIDTH-1:0] attr_read;

  // Widened by one bit so sel = all-ones yields 2^SEL_WIDTH, not zero.
  assign w = {1'b0, signal_sel} + (SEL_WIDTH + 1)'(1);

  pu_unpack_extract #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH),
    .PTR_W      (PTR_W)
  ) u_extract (
    .word    (word_q),
    .ptr     (ptr_q),
    .w       (w),
    .field   (field),
    .overrun (overrun)
  );

  always_comb begin
    ptr_d     = ptr_q;
    st_d      = st_q;
    sum       = SUM_W'(ptr_q) + SUM_W'(w);
    invalid   = (st_q != ST_LOADED) || overrun;
    attr_read = attr_q;
    attr_read[ATTR_INVALID_BIT] = attr_q[ATTR_INVALID_BIT] | invalid;
    data_out  = '0;
    attr_out  = '0;

    if (signal_oe) begin
      data_out = field;
      attr_out = attr_read;
    end

    // A write in the same cycle as a read wins: the read sees the old word.
    if (signal_wr) begin
      ptr_d = '0;
      st_d  = ST_LOADED;
    end else if (signal_oe && st_q == ST_LOADED) begin
      ptr_d = (sum >= SUM_END) ? PTR_END : sum[PTR_W-1:0];
      if (ptr_d == PTR_END) st_d = ST_DRAINED;
    end
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      attr_q <= '0;
      ptr_q  <= '0;
      st_q   <= ST_EMPTY;
    end else begin
      ptr_q <= ptr_d;
      st_q  <= st_d;
      if (signal_wr) begin
        word_q <= data_in;
        attr_q <= attr_in;
      end
    end
  end

endmodule

// File: tb/tb_pu_unpack.sv
// Self-checking bench for pu_unpack: directed scenarios plus randomized
// traffic compared against a bit-level reference model of the unpacker.
module tb_pu_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        signal_wr;
  logic        signal_oe;
  logic [3:0]  signal_sel;
  logic [31:0] data_in;
  logic [3:0]  attr_in;
  logic [31:0] data_out;
  logic [3:0]  attr_out;

  int checks = 0;
  int errors = 0;

  // Reference model: state 0 = empty, 1 = loaded, 2 = drained.
  logic [31:0] m_word;
  logic [3:0]  m_attr;
  int          m_ptr;
  int          m_st;
  logic [31:0] exp_data;
  logic [3:0]  exp_attr;

  pu_unpack dut (
    .clk        (clk),
    .rst        (rst),
    .signal_wr  (signal_wr),
    .signal_oe  (signal_oe),
    .signal_sel (signal_sel),
    .data_in    (data_in),
    .attr_in    (attr_in),
    .data_out   (data_out),
    .attr_out   (attr_out)
  );

  always #5 clk = ~clk;

  task automatic model_expect();
    int w;
    w = int'(signal_sel) + 1;
    exp_data = '0;
    exp_attr = '0;
    if (signal_oe) begin
      for (int i = 0; i < w; i++) begin
        if (m_ptr + i < 32) exp_data[i] = m_word[m_ptr + i];
      end
      exp_attr    = m_attr;
      exp_attr[0] = m_attr[0] | ((m_st != 1) || (m_ptr + w > 32));
    end
  endtask

  task automatic model_update();
    int w;
    w = int'(signal_sel) + 1;
    if (rst) begin
      m_word = '0; m_attr = '0; m_ptr = 0; m_st = 0;
    end else if (signal_wr) begin
      m_word = data_in; m_attr = attr_in; m_ptr = 0; m_st = 1;
    end else if (signal_oe && m_st == 1) begin
      m_ptr = (m_ptr + w > 32) ? 32 : m_ptr + w;
      if (m_ptr == 32) m_st = 2;
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic wr, input logic oe,
                       input logic [3:0] sel, input logic [31:0] d, input logic [3:0] a);
    @(negedge clk);
    rst = r; signal_wr = wr; signal_oe = oe; signal_sel = sel; data_in = d; attr_in = a;
    #1;
    model_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic write_word(input logic [31:0] d, input logic [3:0] a);
    drive(1'b0, 1'b1, 1'b0, 4'd0, d, a);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd5, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_oe_low got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'h0);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'b0001) begin
      errors++;
      $display("FAIL empty_read got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'b0001);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 4'd15, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'b0001) begin
      errors++;
      $display("FAIL empty_still got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'b0001);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [3:0]  sels [4] = '{4'd3, 4'd3, 4'd7, 4'd15};
    logic [31:0] exps [4] = '{32'h5, 32'hA, 32'h0, 32'h0};
    write_word(32'h0000_00A5, 4'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, sels[i], 32'h0, 4'h0);
      checks++;
      if (data_out !== exps[i] || attr_out !== 4'b0000) begin
        errors++;
        $display("FAIL basic_read%0d got data=%h attr=%b want data=%h attr=%b", i, data_out, attr_out, exps[i], 4'b0000);
      end
      tick();
    end
    drive(1'b0, 1'b0, 0, 4'd3, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'h0) begin
      errors++;
      $display("FAIL loaded_oe_low got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'h0);
    end
    tick();
  endtask

  task automatic test_exact_fill();
    logic [3:0]  sels [3] = '{4'd15, 4'd15, 4'd0};
    logic [31:0] exps [3] = '{32'h1234, 32'hF000, 32'h0};
    logic [3:0]  atts [3] = '{4'b0000, 4'b0000, 4'b0001};
    write_word(32'hF000_1234, 4'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, sels[i], 32'h0, 4'h0);
      checks++;
      if (data_out !== exps[i] || attr_out !== atts[i]) begin
        errors++;
        $display("FAIL fill_read%0d got data=%h attr=%b want data=%h attr=%b", i, data_out, attr_out, exps[i], atts[i]);
      end
      tick();
    end
  endtask

  task automatic test_overrun();
    write_word(32'hC000_0000, 4'h0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
      checks++;
      if (data_out !== 32'h0 || attr_out !== 4'b0000) begin
        errors++;
        $display("FAIL over_pre%0d got data=%h attr=%b want data=%h attr=%b", i, data_out, attr_out, 32'h0, 4'b0000);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 4'd7, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'hC || attr_out !== 4'b0001) begin
      errors++;
      $display("FAIL over_partial got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'hC, 4'b0001);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'b0001) begin
      errors++;
      $display("FAIL over_drained got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'b0001);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    write_word(32'h0000_0002, 4'h0);
    drive(1'b0, 1'b1, 1'b1, 4'd0, 32'h0000_000F, 4'h0);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'b0000) begin
      errors++;
      $display("FAIL wr_oe_old got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'b0000);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'hF || attr_out !== 4'b0000) begin
      errors++;
      $display("FAIL wr_oe_new got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'hF, 4'b0000);
    end
    tick();
    // 28 bits remain at ptr=4: a 16-bit read is valid, the next 16 overrun.
    drive(1'b0, 1'b0, 1'b1, 4'd15, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'b0000) begin
      errors++;
      $display("FAIL wr_oe_ptr4 got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'b0000);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 4'd15, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'b0001) begin
      errors++;
      $display("FAIL wr_oe_tail got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'b0001);
    end
    tick();
  endtask

  task automatic test_attr_reset();
    write_word(32'h0000_0053, 4'b0110);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'h3 || attr_out !== 4'b0110) begin
      errors++;
      $display("FAIL attr_pass got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h3, 4'b0110);
    end
    tick();
    // Reset must beat a simultaneous write.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 32'hFFFF_FFFF, 4'b1110);
    tick();
    drive(1'b0, 1'b0, 1'b1, 4'd3, 32'h0, 4'h0);
    checks++;
    if (data_out !== 32'h0 || attr_out !== 4'b0001) begin
      errors++;
      $display("FAIL attr_after_rst got data=%h attr=%b want data=%h attr=%b", data_out, attr_out, 32'h0, 4'b0001);
    end
    tick();
  endtask

  task automatic test_random();
    logic r, wr, oe;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      wr = ($urandom_range(0, 6) == 0);
      oe = ($urandom_range(0, 3) != 0);
      drive(r, wr, oe, 4'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(0, 15)));
      checks++;
      if (data_out !== exp_data || attr_out !== exp_attr) begin
        errors++;
        $display("FAIL random%0d got data=%h attr=%b want data=%h attr=%b", i, data_out, attr_out, exp_data, exp_attr);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; signal_wr = 1'b0; signal_oe = 1'b0; signal_sel = '0; data_in = '0; attr_in = '0;
    m_word = '0; m_attr = '0; m_ptr = 0; m_st = 0; exp_data = '0; exp_attr = '0;
    test_reset();
    test_basic();
    test_exact_fill();
    test_overrun();
    test_back_to_back();
    test_attr_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
